// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio record/playback path.
//   ADDR_W / DATA_W     : external SRAM address and data widths
//   SPEED_MIN/SPEED_MAX : legal range of the player speed settings
//   audio_state_e       : sequencer state encoding (exported on audio_ctrl.state)
//   CMD_*               : bit positions of the one-hot key command
//   clamp_speed()       : clamps a requested speed into SPEED_MIN..SPEED_MAX
package audio_pkg;

    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int SPEED_W = 4;

    localparam logic [SPEED_W-1:0] SPEED_MIN = 4'd1;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 4'd8;

    // Last SRAM word; recording stops here instead of wrapping.
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RECORD     = 3'd1,
        ST_PLAY       = 3'd2,
        ST_REC_PAUSE  = 3'd3,
        ST_PLAY_PAUSE = 3'd4
    } audio_state_e;

    // One-hot command produced by audio_key_decode.
    localparam int CMD_W     = 4;
    localparam int CMD_PLAY  = 0;
    localparam int CMD_REC   = 1;
    localparam int CMD_PAUSE = 2;
    localparam int CMD_STOP  = 3;

    function automatic logic [SPEED_W-1:0] clamp_speed(input logic [SPEED_W-1:0] v);
        logic [SPEED_W-1:0] r;
        r = v;
        if (v < SPEED_MIN) begin
            r = SPEED_MIN;
        end else if (v > SPEED_MAX) begin
            r = SPEED_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_key_decode.sv
// audio_key_decode: priority-encodes the four front-panel key pulses into a
// registered one-hot command (stop > pause > rec > play).
//   bclk, rst                         : clock, synchronous active-high reset
//   key_rec/key_play/key_pause/key_stop : single-cycle debounced key pulses
//   cmd                               : one-hot command, bit positions CMD_* in audio_pkg,
//                                       valid for one cycle, one cycle after the key pulse
module audio_key_decode
    import audio_pkg::*;
(
    input  logic             bclk,
    input  logic             rst,
    input  logic             key_rec,
    input  logic             key_play,
    input  logic             key_pause,
    input  logic             key_stop,
    output logic [CMD_W-1:0] cmd
);

    always_ff @(posedge bclk) begin
        if (rst) begin
            cmd <= '0;
        end else begin
            cmd <= '0;
            if (key_stop) begin
                cmd[CMD_STOP] <= 1'b1;
            end else if (key_pause) begin
                cmd[CMD_PAUSE] <= 1'b1;
            end else if (key_rec) begin
                cmd[CMD_REC] <= 1'b1;
            end else if (key_play) begin
                cmd[CMD_PLAY] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_ctrl.sv
// audio_ctrl: record/playback sequencer and owner of the single SRAM port.
// Optional feature: define AUDIO_CTRL_LOOP_EN for loop playback (reaching
// end_addr in PLAY restarts the player instead of returning to IDLE).
//
// Ports:
//   bclk, rst            : only clock, synchronous active-high reset
//   key_*                : single-cycle command pulses (stop > pause > rec > play)
//   fast_in, slow_in     : requested speed, clamped to 1..8 on PLAY entry from IDLE
//   slowmethod_in        : slow-down method, latched on PLAY entry from IDLE
//   rec_valid, rec_data  : recorder sample strobe and data (used in RECORD only)
//   play_addr            : player's current read address
//   rec_en, play_en      : high in RECORD / PLAY respectively
//   play_restart         : one-cycle pulse, player reloads its address to 0
//   fast, slow, slowmethod : speed settings handed to the player
//   end_addr             : one past the last recorded word (18'h3FFFF when full)
//   full                 : SRAM filled during the last recording
//   state                : current sequencer state (audio_state_e encoding)
//   sram_*               : external asynchronous SRAM port (active-low strobes)
//
// Handshake: rec_valid is a one-cycle strobe with no back-pressure; a strobe
// seen in RECORD is always written, as one we_n-low cycle directly after it.
module audio_ctrl
    import audio_pkg::*;
(
    input  logic                bclk,
    input  logic                rst,
    input  logic                key_rec,
    input  logic                key_play,
    input  logic                key_pause,
    input  logic                key_stop,
    input  logic [3:0]          fast_in,
    input  logic [3:0]          slow_in,
    input  logic                slowmethod_in,
    input  logic                rec_valid,
    input  logic [DATA_W-1:0]   rec_data,
    input  logic [ADDR_W-1:0]   play_addr,
    output logic                rec_en,
    output logic                play_en,
    output logic                play_restart,
    output logic [3:0]          fast,
    output logic [3:0]          slow,
    output logic                slowmethod,
    output logic [ADDR_W-1:0]   end_addr,
    output logic                full,
    output logic [2:0]          state,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_dq_out,
    output logic                sram_dq_oe,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n
);

    logic [CMD_W-1:0] cmd;

    audio_key_decode u_key_decode (
        .bclk      (bclk),
        .rst       (rst),
        .key_rec   (key_rec),
        .key_play  (key_play),
        .key_pause (key_pause),
        .key_stop  (key_stop),
        .cmd       (cmd)
    );

    audio_state_e      state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_d, wr_ptr_inc;
    logic [ADDR_W-1:0] end_addr_d;
    logic              full_d;
    logic              wr_fire;
    logic              load_speed;
    logic              restart_d;
    logic              we_n_q, dq_oe_q;
    logic              ce_n_d, oe_n_d, we_n_d, dq_oe_d;
    logic [ADDR_W-1:0] addr_d;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr;
        end_addr_d = end_addr;
        full_d     = full;
        load_speed = 1'b0;
        restart_d  = 1'b0;

        wr_fire = (state_q == ST_RECORD) && rec_valid;
        // The pointer saturates at the last word; the write there ends recording.
        wr_ptr_inc = (wr_fire && (wr_ptr != ADDR_LAST)) ? (wr_ptr + ADDR_W'(1)) : wr_ptr;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd[CMD_REC]) begin
                    state_d  = ST_RECORD;
                    wr_ptr_d = '0;
                    full_d   = 1'b0;
                end else if (cmd[CMD_PLAY] && (end_addr != '0)) begin
                    state_d    = ST_PLAY;
                    load_speed = 1'b1;
                    restart_d  = 1'b1;
                end
            end

            ST_RECORD: begin
                wr_ptr_d = wr_ptr_inc;
                if (wr_fire && (wr_ptr == ADDR_LAST)) begin
                    full_d     = 1'b1;
                    end_addr_d = ADDR_LAST;
                    state_d    = ST_IDLE;
                end else if (cmd[CMD_STOP]) begin
                    // A sample strobed alongside stop is counted in end_addr.
                    end_addr_d = wr_ptr_inc;
                    state_d    = ST_IDLE;
                end else if (cmd[CMD_PAUSE]) begin
                    state_d = ST_REC_PAUSE;
                end
            end

            ST_REC_PAUSE: begin
                if (cmd[CMD_STOP]) begin
                    end_addr_d = wr_ptr;
                    state_d    = ST_IDLE;
                end else if (cmd[CMD_PAUSE] || cmd[CMD_REC]) begin
                    state_d = ST_RECORD;
                end
            end

            ST_PLAY: begin
                if (cmd[CMD_STOP]) begin
                    state_d = ST_IDLE;
                end else if (cmd[CMD_PAUSE]) begin
                    state_d = ST_PLAY_PAUSE;
                end else if (play_addr >= end_addr) begin
`ifdef AUDIO_CTRL_LOOP_EN
                    restart_d = 1'b1;
`else
                    state_d = ST_IDLE;
`endif
                end
            end

            ST_PLAY_PAUSE: begin
                if (cmd[CMD_STOP]) begin
                    state_d = ST_IDLE;
                end else if (cmd[CMD_PAUSE] || cmd[CMD_PLAY]) begin
                    state_d = ST_PLAY;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SRAM port for the coming cycle. A write strobed in the last RECORD
        // cycle still completes even though the state has already moved on.
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        addr_d  = '0;
        if (state_d == ST_PLAY) begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
            addr_d = play_addr;
        end else if (state_d == ST_RECORD) begin
            ce_n_d = 1'b0;
            addr_d = wr_ptr_d;
        end
        if (wr_fire) begin
            ce_n_d  = 1'b0;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b0;
            dq_oe_d = 1'b1;
            addr_d  = wr_ptr;
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr       <= '0;
            end_addr     <= '0;
            full         <= 1'b0;
            rec_en       <= 1'b0;
            play_en      <= 1'b0;
            play_restart <= 1'b0;
            fast         <= SPEED_MIN;
            slow         <= SPEED_MIN;
            slowmethod   <= 1'b0;
            sram_addr    <= '0;
            sram_dq_out  <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            we_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr       <= wr_ptr_d;
            end_addr     <= end_addr_d;
            full         <= full_d;
            rec_en       <= (state_d == ST_RECORD);
            play_en      <= (state_d == ST_PLAY);
            play_restart <= restart_d;
            if (load_speed) begin
                fast       <= clamp_speed(fast_in);
                slow       <= clamp_speed(slow_in);
                slowmethod <= slowmethod_in;
            end
            sram_addr <= addr_d;
            if (wr_fire) begin
                sram_dq_out <= rec_data;
            end
            sram_ce_n <= ce_n_d;
            sram_oe_n <= oe_n_d;
            we_n_q    <= we_n_d;
            dq_oe_q   <= dq_oe_d;
        end
    end

    // Reset asserted during a write cycle must suppress that write immediately,
    // so the write strobe and bus drive are gated by rst after the register.
    assign sram_we_n  = we_n_q | rst;
    assign sram_dq_oe = dq_oe_q & ~rst;
    assign state      = state_q;

endmodule

// File: tb/tb_audio_ctrl.sv
// tb_audio_ctrl: self-checking bench for audio_ctrl. Randomized recordings and
// speed settings are checked against a behavioural model of the SRAM contents
// (expected write queue) and the mode/length bookkeeping.
module tb_audio_ctrl;
    import audio_pkg::*;

    localparam logic [3:0] K_PLAY  = 4'b0001;
    localparam logic [3:0] K_REC   = 4'b0010;
    localparam logic [3:0] K_PAUSE = 4'b0100;
    localparam logic [3:0] K_STOP  = 4'b1000;
    localparam logic [ADDR_W-1:0] LAST = 18'h3FFFF;
    localparam int WE = ADDR_W + DATA_W + 2;

    logic              bclk;
    logic              rst;
    logic              key_rec, key_play, key_pause, key_stop;
    logic [3:0]        fast_in, slow_in;
    logic              slowmethod_in;
    logic              rec_valid;
    logic [DATA_W-1:0] rec_data;
    logic [ADDR_W-1:0] play_addr;
    logic              rec_en, play_en, play_restart;
    logic [3:0]        fast, slow;
    logic              slowmethod;
    logic [ADDR_W-1:0] end_addr;
    logic              full;
    logic [2:0]        state;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    audio_ctrl dut (
        .bclk          (bclk),
        .rst           (rst),
        .key_rec       (key_rec),
        .key_play      (key_play),
        .key_pause     (key_pause),
        .key_stop      (key_stop),
        .fast_in       (fast_in),
        .slow_in       (slow_in),
        .slowmethod_in (slowmethod_in),
        .rec_valid     (rec_valid),
        .rec_data      (rec_data),
        .play_addr     (play_addr),
        .rec_en        (rec_en),
        .play_en       (play_en),
        .play_restart  (play_restart),
        .fast          (fast),
        .slow          (slow),
        .slowmethod    (slowmethod),
        .end_addr      (end_addr),
        .full          (full),
        .state         (state),
        .sram_addr     (sram_addr),
        .sram_dq_out   (sram_dq_out),
        .sram_dq_oe    (sram_dq_oe),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n)
    );

    // ---------------- clock / reset ----------------
    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [WE-1:0] exp_q[$];   // {oe_n, dq_oe, addr, data} of each expected write
    logic [WE-1:0] obs_q[$];

    // Reference model of the recording bookkeeping.
    logic              m_rec;   // samples are being stored
    logic [ADDR_W-1:0] m_wr;    // next address to be written
    logic [ADDR_W-1:0] m_end;
    logic              m_full;

    // SRAM model: every cycle with ce_n and we_n low is one stored word.
    always @(negedge bclk) begin
        if (!sram_ce_n && !sram_we_n) begin
            obs_q.push_back({sram_oe_n, sram_dq_oe, sram_addr, sram_dq_out});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_word"}, 64'(obs_q[i]), 64'(exp_q[i]));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    function automatic int exp_clamp(input int v);
        if (v < 1) return 1;
        if (v > 8) return 8;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    // Pulse keys for one cycle, then wait for the command to take effect.
    task automatic press(input logic [3:0] k);
        {key_stop, key_pause, key_rec, key_play} = k;
        tick();
        {key_stop, key_pause, key_rec, key_play} = 4'b0000;
        tick();
    endtask

    task automatic model_sample(input logic [DATA_W-1:0] d);
        if (m_rec) begin
            exp_q.push_back({1'b1, 1'b1, m_wr, d});
            if (m_wr == LAST) begin
                m_full = 1'b1;
                m_end  = LAST;
                m_rec  = 1'b0;
            end else begin
                m_wr = m_wr + 1'b1;
            end
        end
    endtask

    task automatic send_sample(input logic [DATA_W-1:0] d);
        rec_valid = 1'b1;
        rec_data  = d;
        model_sample(d);
        tick();
        rec_valid = 1'b0;
    endtask

    task automatic start_record();
        press(K_REC);
        m_rec  = 1'b1;
        m_wr   = '0;
        m_full = 1'b0;
        chk("rec_state", 64'(state), 64'(ST_RECORD));
        chk("rec_en", 64'(rec_en), 64'd1);
        chk("rec_full_clr", 64'(full), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 64'(state), 64'(ST_IDLE));
        chk({tag, "_end"}, 64'(end_addr), 64'd0);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_en"}, 64'({rec_en, play_en, play_restart}), 64'd0);
        chk({tag, "_speed"}, 64'({fast, slow, slowmethod}), 64'({4'd1, 4'd1, 1'b0}));
        chk({tag, "_sram_ctl"}, 64'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 64'b1110);
        chk({tag, "_sram_addr"}, 64'(sram_addr), 64'd0);
        chk({tag, "_sram_dq"}, 64'(sram_dq_out), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int fi, si;
        logic sm;
        rst = 1'b1;
        {key_stop, key_pause, key_rec, key_play} = 4'b0000;
        fast_in = '0; slow_in = '0; slowmethod_in = 1'b0;
        rec_valid = 1'b0; rec_data = '0; play_addr = '0;
        m_rec = 1'b0; m_wr = '0; m_end = '0; m_full = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_values("reset");

        // Play with nothing recorded stays idle.
        press(K_PLAY);
        chk("play_empty_state", 64'(state), 64'(ST_IDLE));
        chk("play_empty_en", 64'(play_en), 64'd0);
        chk("play_empty_restart", 64'(play_restart), 64'd0);

        // Directed recording of 1..5.
        start_record();
        chk("rec_sram_ctl", 64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'b011);
        for (int d = 1; d <= 5; d++) begin
            send_sample(16'(d));
            repeat ($urandom_range(0, 2)) tick();
        end
        press(K_STOP);
        m_rec = 1'b0; m_end = m_wr;
        chk("stop_state", 64'(state), 64'(ST_IDLE));
        chk("stop_end", 64'(end_addr), 64'(m_end));
        chk("stop_ce_n", 64'(sram_ce_n), 64'd1);
        tick();
        check_writes("rec5");

        // Sample outside RECORD is ignored.
        send_sample(16'hBEEF);
        tick();
        check_writes("idle_sample");

        // Playback with clamped speeds.
        play_addr = '0; fast_in = 4'd0; slow_in = 4'd12; slowmethod_in = 1'b1;
        press(K_PLAY);
        chk("play_state", 64'(state), 64'(ST_PLAY));
        chk("play_en", 64'(play_en), 64'd1);
        chk("play_restart", 64'(play_restart), 64'd1);
        chk("play_speed", 64'({fast, slow, slowmethod}), 64'({4'd1, 4'd8, 1'b1}));
        play_addr = 18'd3;
        tick();
        chk("play_restart_pulse", 64'(play_restart), 64'd0);
        chk("play_sram_ctl", 64'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 64'b0010);
        chk("play_sram_addr", 64'(sram_addr), 64'd3);
        play_addr = 18'd5;
        tick();
`ifdef AUDIO_CTRL_LOOP_EN
        chk("loop_state", 64'(state), 64'(ST_PLAY));
        chk("loop_restart", 64'(play_restart), 64'd1);
        play_addr = '0;
        tick();
        press(K_STOP);
`endif
        chk("play_end_state", 64'(state), 64'(ST_IDLE));
        chk("play_end_en", 64'(play_en), 64'd0);
        play_addr = '0;

        // Pause/resume in PLAY keeps the speed; stop beats pause.
        fi = int'($urandom_range(0, 15)); si = int'($urandom_range(0, 15)); sm = 1'($urandom_range(0, 1));
        fast_in = 4'(fi); slow_in = 4'(si); slowmethod_in = sm;
        press(K_PLAY);
        chk("play2_speed", 64'({fast, slow, slowmethod}), 64'({4'(exp_clamp(fi)), 4'(exp_clamp(si)), sm}));
        press(K_PAUSE);
        chk("ppause_state", 64'(state), 64'(ST_PLAY_PAUSE));
        chk("ppause_ctl", 64'({play_en, sram_ce_n, sram_oe_n}), 64'b011);
        fast_in = 4'(fi ^ 5); slow_in = 4'(si ^ 3); slowmethod_in = ~sm;
        press(K_PLAY);
        chk("presume_state", 64'(state), 64'(ST_PLAY));
        chk("presume_restart", 64'(play_restart), 64'd0);
        chk("presume_speed", 64'({fast, slow, slowmethod}), 64'({4'(exp_clamp(fi)), 4'(exp_clamp(si)), sm}));
        press(K_STOP | K_PAUSE);
        chk("stop_pause_state", 64'(state), 64'(ST_IDLE));

        // Full SRAM: pointer preloaded close to the top, continuous strobes.
        start_record();
        force dut.wr_ptr = 18'h3FFFC;
        tick();
        release dut.wr_ptr;
        m_wr = 18'h3FFFC;
        for (int i = 0; i < 8; i++) begin
            rec_valid = 1'b1;
            rec_data  = 16'($urandom);
            model_sample(rec_data);
            tick();
        end
        rec_valid = 1'b0;
        tick();
        chk("full_flag", 64'(full), 64'(m_full));
        chk("full_end", 64'(end_addr), 64'(LAST));
        chk("full_state", 64'(state), 64'(ST_IDLE));
        check_writes("full");
        m_end = LAST;

        // Pause/resume in RECORD keeps the write pointer.
        start_record();
        repeat (3) send_sample(16'($urandom));
        press(K_PAUSE);
        m_rec = 1'b0;
        chk("rpause_state", 64'(state), 64'(ST_REC_PAUSE));
        chk("rpause_ctl", 64'({rec_en, sram_ce_n}), 64'b01);
        send_sample(16'($urandom));
        press(K_PAUSE);
        m_rec = 1'b1;
        chk("rresume_state", 64'(state), 64'(ST_RECORD));
        repeat (2) send_sample(16'($urandom));
        press(K_PAUSE);
        m_rec = 1'b0;
        press(K_REC);
        m_rec = 1'b1;
        chk("rresume2_state", 64'(state), 64'(ST_RECORD));
        send_sample(16'($urandom));
        // Sample strobed together with stop is kept and counted.
        key_stop  = 1'b1;
        rec_valid = 1'b1;
        rec_data  = 16'($urandom);
        model_sample(rec_data);
        tick();
        key_stop  = 1'b0;
        rec_valid = 1'b0;
        tick();
        m_rec = 1'b0; m_end = m_wr;
        chk("stopvalid_state", 64'(state), 64'(ST_IDLE));
        chk("stopvalid_end", 64'(end_addr), 64'(m_end));
        tick();
        check_writes("pause_rec");

        // Randomized record / play rounds.
        for (int r = 0; r < 3; r++) begin
            start_record();
            n = int'($urandom_range(3, 10));
            for (int i = 0; i < n; i++) begin
                send_sample(16'($urandom));
                repeat ($urandom_range(0, 2)) tick();
                if (i == 1 && $urandom_range(0, 1) == 1) begin
                    press(K_PAUSE);
                    m_rec = 1'b0;
                    send_sample(16'($urandom));
                    press(K_PAUSE);
                    m_rec = 1'b1;
                end
            end
            press(K_STOP);
            m_rec = 1'b0; m_end = m_wr;
            chk("rnd_end", 64'(end_addr), 64'(n));
            tick();
            check_writes("rnd_rec");

            fi = int'($urandom_range(0, 15)); si = int'($urandom_range(0, 15)); sm = 1'($urandom_range(0, 1));
            fast_in = 4'(fi); slow_in = 4'(si); slowmethod_in = sm;
            play_addr = '0;
            press(K_PLAY);
            chk("rnd_restart", 64'(play_restart), 64'd1);
            chk("rnd_speed", 64'({fast, slow, slowmethod}), 64'({4'(exp_clamp(fi)), 4'(exp_clamp(si)), sm}));
            play_addr = 18'($urandom_range(0, n - 1));
            tick();
            chk("rnd_play_state", 64'(state), 64'(ST_PLAY));
            chk("rnd_play_addr", 64'(sram_addr), 64'(play_addr));
            play_addr = 18'(n + int'($urandom_range(0, 3)));
            tick();
`ifdef AUDIO_CTRL_LOOP_EN
            chk("rnd_loop_state", 64'(state), 64'(ST_PLAY));
            chk("rnd_loop_restart", 64'(play_restart), 64'd1);
            play_addr = '0;
            tick();
            press(K_STOP);
`endif
            chk("rnd_end_state", 64'(state), 64'(ST_IDLE));
            play_addr = '0;
        end

        // Reset in the write cycle suppresses the write.
        start_record();
        rec_valid = 1'b1;
        rec_data  = 16'hA5A5;
        tick();
        rec_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("rst_mid_write");
        tick();
        check_writes("rst_mid_write");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_ctrl.md
# audio_ctrl

Record/playback sequencer for the audio path. It turns front-panel key pulses into a mode state machine and owns the single external SRAM port. The SRAM is shared between the ADC-side recorder (writes) and the DAC-side player (reads). The block also tracks the recorded length and hands clamped speed settings (fast, slow, slowmethod) to the player.

## Interface
- Parameters: none. Widths come from the shared package: ADDR_W=18, DATA_W=16.
- Ports:
- bclk  in  1  codec bit clock; the only clock
- rst  in  1  synchronous, active-high reset
- key_rec / key_play / key_pause / key_stop  in  1 each  single-cycle, debounced command pulses
- fast_in  in  4  requested playback address step
- slow_in  in  4  requested slow-down factor
- slowmethod_in  in  1  slow-down method select, passed through
- rec_valid  in  1  one-cycle pulse: rec_data is ready to store
- rec_data  in  16  recorder sample
- play_addr  in  18  player's current read address
- rec_en / play_en  out  1  enables to the recorder and player
- play_restart  out  1  one-cycle pulse: player must reload its address to 0
- fast / slow  out  4  clamped speed settings
- slowmethod  out  1  latched slowmethod_in
- end_addr  out  18  one past the last recorded word
- full  out  1  SRAM filled during recording
- state  out  3  current FSM state encoding
- sram_addr  out  18; sram_dq_out  out  16; sram_dq_oe  out  1; sram_ce_n / sram_oe_n / sram_we_n  out  1

## Operation
- States: IDLE, RECORD, PLAY, REC_PAUSE, PLAY_PAUSE.
- Key priority when several keys pulse in the same cycle: stop > pause > rec > play.
- IDLE:
  - key_rec → RECORD; write pointer wr_ptr cleared to 0 and full cleared.
  - key_play → PLAY, only if end_addr != 0; otherwise stay in IDLE.
- RECORD:
  - Each rec_valid writes rec_data at wr_ptr, then wr_ptr increments.
  - A write at wr_ptr = 18'h3FFFF sets full=1, sets end_addr = 18'h3FFFF and returns to IDLE; the pointer never wraps.
  - key_stop: end_addr ← wr_ptr, then IDLE.
  - key_pause → REC_PAUSE.
- REC_PAUSE: key_pause or key_rec → RECORD, wr_ptr kept. key_stop behaves as in RECORD.
- PLAY:
  - Entry loads fast = clamp(fast_in,1,8), slow = clamp(slow_in,1,8), slowmethod = slowmethod_in. These values hold until the next PLAY entry.
  - Entry from IDLE pulses play_restart.
  - play_addr >= end_addr → IDLE.
  - key_stop → IDLE; key_pause → PLAY_PAUSE.
- PLAY_PAUSE: key_pause or key_play → PLAY without play_restart and without reloading speed. key_stop → IDLE.
- rec_en = 1 in RECORD only. play_en = 1 in PLAY only.
- SRAM port:
  - IDLE and pauses: ce_n=oe_n=we_n=1, dq_oe=0, addr=0.
  - PLAY: ce_n=0, oe_n=0, addr=play_addr.
  - RECORD: ce_n=0, oe_n=1, addr=wr_ptr; we_n=0 and dq_oe=1 only in the cycle after rec_valid, with data registered.
- Width rules: wr_ptr and end_addr are unsigned 18-bit. The play_addr comparison is unsigned.

## Timing
- All outputs are registered; a key pulse in cycle N changes state and outputs at the edge ending N+1.
- Reset (any state, including mid-write):
  - state=IDLE, wr_ptr=0, end_addr=0, full=0, rec_en=play_en=play_restart=0.
  - fast=slow=1, slowmethod=0.
  - SRAM controls all 1, dq_oe=0, sram_addr=0, sram_dq_out=0.
  - A write pending at reset is discarded.
- A write pulse is exactly one cycle. A rec_valid arriving in the same cycle as key_stop is still written, and end_addr includes it.
- rec_valid outside RECORD is ignored.
- play_restart is a single-cycle pulse, high in the first PLAY cycle.

## Configuration
- AUDIO_CTRL_LOOP_EN defined: in PLAY, play_addr >= end_addr pulses play_restart and stays in PLAY (loop playback).
- Not defined: the same condition returns to IDLE.

## Structure
- Package audio_pkg holds:
  - the state enum;
  - ADDR_W, DATA_W;
  - SPEED_MIN=1, SPEED_MAX=8;
  - the clamp function.
- One sub-module, audio_key_decode: priority-encodes the four key pulses into a one-hot command.

## Test plan
- Reset, key_rec, 5 rec_valid pulses with data 16'h0001..16'h0005, key_stop → SRAM writes at addresses 0..4, end_addr=5, state returns to IDLE.
- After that recording, key_play with fast_in=0, slow_in=12 → play_restart one cycle, fast=1, slow=8. Driving play_addr=5 → IDLE (with AUDIO_CTRL_LOOP_EN: play_restart again, state stays PLAY).
- key_play with end_addr=0 → state stays IDLE, play_en=0.
- Record with wr_ptr preloaded by continuous rec_valid to 18'h3FFFF → full=1, end_addr=18'h3FFFF, IDLE, no wrap write to address 0.
- key_stop and key_pause pulsed in the same cycle during PLAY → IDLE. key_pause twice during RECORD → REC_PAUSE then RECORD, wr_ptr unchanged.
- rst asserted in the cycle after rec_valid → no we_n pulse, all outputs at reset values.
